shift_frame_tx: RTL and testbench

- Parallel-to-serial transmitter; the sending end of the serial path into our 4-bit universal shift registers.
- Accepts a parallel word through a valid/ready handshake and serialises it onto one data line.
- Drives a one-cycle bit strobe that the receiving shift register uses as its shift enable, plus a frame-done pulse.
- Bit order is selectable per word, to match a receiver shifting right or left.

---
 rtl/shift_frame_tx.sv | 92 +++++++++
 tb/tb_shift_frame_tx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/shift_frame_tx.sv
// Parallel-to-serial transmitter: valid/ready word in, SOUT plus bit strobe, frame and done out.
// First bit appears the cycle after accept; a frame lasts WIDTH*DIV cycles, then GAP idle cycles.
module shift_frame_tx #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1,
  parameter int GAP   = 1
) (
  input  logic             CLK,
  input  logic             MR,
  input  logic [WIDTH-1:0] IN,
  input  logic             DIR,
  input  logic             VALID,
  output logic             READY,
  output logic             SOUT,
  output logic             STB,
  output logic             FRAME,
  output logic             DONE
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state, state_nxt;
  logic             in_rst;
  logic [WIDTH-1:0] sreg;
  logic             dir_q;
  logic [CW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             accept;

  // in_rst keeps READY low for the cycle following a sampled reset
  assign READY  = (state == S_IDLE) && !in_rst;
  assign FRAME  = (state == S_SHIFT);
  assign STB    = FRAME && (div_cnt == '0);
  assign DONE   = STB && (bit_cnt == '0);
  assign SOUT   = FRAME && (dir_q ? sreg[0] : sreg[WIDTH-1]);
  assign accept = VALID && READY;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SHIFT;
      S_SHIFT: if (DONE) state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_cnt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      state   <= S_IDLE;
      in_rst  <= 1'b1;
      sreg    <= '0;
      dir_q   <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state  <= state_nxt;
      in_rst <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            sreg    <= IN;
            dir_q   <= DIR;
            bit_cnt <= CW'(WIDTH - 1);
            div_cnt <= DW'(DIV - 1);
          end
        end
        S_SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else if (bit_cnt != '0) begin
            // advance toward the next bit in the latched order
            sreg    <= dir_q ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt - 1'b1;
            div_cnt <= DW'(DIV - 1);
          end else begin
            gap_cnt <= GW'(GAP - 1);
          end
        end
        S_GAP: gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_frame_tx.sv
// Directed bench for shift_frame_tx: three instances (DIV=1/GAP=0, DIV=3/GAP=0, DIV=1/GAP=2).
module tb_shift_frame_tx;

  logic       CLK = 1'b0;
  logic       MR;
  logic [3:0] IN;
  logic       DIR;
  logic [2:0] valid;
  logic [2:0] rdy, so, st, fr, dn;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  shift_frame_tx #(.WIDTH(4), .DIV(1), .GAP(0)) u0 (
    .CLK(CLK), .MR(MR), .IN(IN), .DIR(DIR), .VALID(valid[0]),
    .READY(rdy[0]), .SOUT(so[0]), .STB(st[0]), .FRAME(fr[0]), .DONE(dn[0]));
  shift_frame_tx #(.WIDTH(4), .DIV(3), .GAP(0)) u1 (
    .CLK(CLK), .MR(MR), .IN(IN), .DIR(DIR), .VALID(valid[1]),
    .READY(rdy[1]), .SOUT(so[1]), .STB(st[1]), .FRAME(fr[1]), .DONE(dn[1]));
  shift_frame_tx #(.WIDTH(4), .DIV(1), .GAP(2)) u2 (
    .CLK(CLK), .MR(MR), .IN(IN), .DIR(DIR), .VALID(valid[2]),
    .READY(rdy[2]), .SOUT(so[2]), .STB(st[2]), .FRAME(fr[2]), .DONE(dn[2]));

  // Receiver model fed by u0. Bit 0 is the serial-input end in right mode and
  // bit 3 in left mode, so right mode pairs with DIR=0 and left mode with DIR=1.
  logic [3:0] rx_q = '0;
  logic       rx_left = 1'b0;
  always @(posedge CLK)
    if (st[0]) rx_q <= rx_left ? {so[0], rx_q[3:1]} : {rx_q[2:0], so[0]};

  typedef struct {
    logic [3:0] word;
    logic       dir;
    logic [3:0] seq;   // expected SOUT, seq[3] is the first bit on the line
  } vec_t;
  vec_t tbl[5];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Accept a word on u0 and check the whole DIV=1/GAP=0 frame plus READY return.
  task automatic run0(input logic [3:0] w, input logic d, input logic [3:0] seq);
    chk("u0 ready before accept", rdy[0], 1);
    IN = w; DIR = d; valid[0] = 1'b1;
    tick;
    valid[0] = 1'b0;
    IN = ~w;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u0 sout w=%b bit%0d", w, i), so[0], seq[3-i]);
      chk("u0 stb", st[0], 1);
      chk("u0 frame", fr[0], 1);
      chk("u0 done", dn[0], (i == 3));
      chk("u0 ready busy", rdy[0], 0);
      tick;
    end
    chk("u0 ready after frame", rdy[0], 1);
    chk("u0 frame after", fr[0], 0);
    chk("u0 done after", dn[0], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b1011, 1'b0, 4'b1011};
    tbl[1] = '{4'b1011, 1'b1, 4'b1101};
    tbl[2] = '{4'b0110, 1'b0, 4'b0110};
    tbl[3] = '{4'b0001, 1'b1, 4'b1000};
    tbl[4] = '{4'b1100, 1'b1, 4'b0011};

    MR = 1'b1; IN = '0; DIR = 1'b0; valid = '0;
    tick; tick;
    chk("reset ready", rdy, 3'b000);
    chk("reset sout", so, 3'b000);
    chk("reset stb", st, 3'b000);
    chk("reset frame", fr, 3'b000);
    chk("reset done", dn, 3'b000);
    MR = 1'b0;
    tick;
    chk("ready after reset", rdy, 3'b111);

    for (int v = 0; v < 5; v++) run0(tbl[v].word, tbl[v].dir, tbl[v].seq);

    // DIV=3: each bit held three cycles, strobe on the third
    IN = 4'b1001; DIR = 1'b0; valid[1] = 1'b1;
    tick;
    valid[1] = 1'b0;
    for (int j = 0; j < 12; j++) begin
      chk($sformatf("u1 sout c%0d", j + 1), so[1], (j < 3 || j >= 9));
      chk($sformatf("u1 stb c%0d", j + 1), st[1], (j % 3 == 2));
      chk($sformatf("u1 done c%0d", j + 1), dn[1], (j == 11));
      chk("u1 frame", fr[1], 1);
      tick;
    end
    chk("u1 ready after", rdy[1], 1);

    // GAP=2 with VALID held and IN churning during the frame
    IN = 4'b1010; DIR = 1'b0; valid[2] = 1'b1;
    tick;
    for (int c = 1; c <= 6; c++) begin
      IN = 4'(c * 5 + 3);
      if (c <= 4) chk($sformatf("u2 sout c%0d", c), so[2], (4'b1010 >> (4 - c)) & 1);
      chk($sformatf("u2 done c%0d", c), dn[2], (c == 4));
      chk($sformatf("u2 ready c%0d", c), rdy[2], 0);
      tick;
    end
    IN = 4'b0111;
    chk("u2 ready c7", rdy[2], 1);
    tick;
    valid[2] = 1'b0;
    IN = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("u2 second sout b%0d", c), so[2], (4'b0111 >> (3 - c)) & 1);
      chk($sformatf("u2 second done b%0d", c), dn[2], (c == 3));
      tick;
    end
    tick; tick;
    chk("u2 ready after gap", rdy[2], 1);

    // Reset mid-frame aborts without DONE
    IN = 4'b1101; DIR = 1'b0; valid[0] = 1'b1;
    tick;
    valid[0] = 1'b0;
    tick;
    MR = 1'b1;
    for (int r = 0; r < 2; r++) begin
      tick;
      chk("abort sout", so[0], 0);
      chk("abort stb", st[0], 0);
      chk("abort frame", fr[0], 0);
      chk("abort done", dn[0], 0);
      chk("abort ready", rdy[0], 0);
    end
    MR = 1'b0;
    tick;
    chk("abort ready after", rdy[0], 1);
    for (int r = 0; r < 4; r++) begin
      chk("abort no late done", dn[0], 0);
      chk("abort no late frame", fr[0], 0);
      tick;
    end
    run0(4'b0110, 1'b0, 4'b0110);

    // Loopback into the receiver model, right mode then left mode
    for (int m = 0; m < 2; m++) begin
      rx_left = (m == 1);
      for (int n = 0; n < 16; n++) begin
        logic [3:0] w;
        w = 4'($urandom_range(0, 15));
        IN = w; DIR = (m == 1); valid[0] = 1'b1;
        tick;
        valid[0] = 1'b0;
        for (int b = 0; b < 4; b++) tick;
        chk($sformatf("loopback m%0d w=%b", m, w), rx_q, w);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
